// File: rtl/amstrad_tape_pulse_player_pkg.sv
// amstrad_tape_pulse_player_pkg: shared state encodings and width helper for the tape player
package amstrad_tape_pulse_player_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, RUN, HOLD} state_t;
  function automatic int pre_w(input int t_div);
    return t_div > 1 ? $clog2(t_div) : 1;
  endfunction
endpackage

// File: rtl/amstrad_tape_pulse_player_if.sv
// amstrad_tape_pulse_player_if: valid/ready stream of pulse lengths in microseconds
interface amstrad_tape_pulse_player_if #(parameter int LEN_W = 16);
  logic valid;
  logic ready;
  logic [LEN_W-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/amstrad_tape_pulse_player_tape_fifo.sv
// tape_fifo: synchronous pulse-length FIFO with flush, level and full/empty flags
module tape_fifo #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [LEN_W-1:0]         wdata,
  output logic [LEN_W-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [LEN_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/amstrad_tape_pulse_player.sv
// amstrad_tape_pulse_player: CSW-style pulse player toggling tape_in as each microsecond length expires
module amstrad_tape_pulse_player
  import amstrad_tape_pulse_player_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16,
  parameter int T_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic                   play,
  input  logic                   motor,
  amstrad_tape_pulse_player_if.slave s,
  output logic                   tape_in,
  output logic                   active,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int PW = pre_w(T_DIV);
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [LEN_W-1:0] cnt, cnt_n, head;
  logic lvl_n, und_n, ready_q, pop, full, empty, wrap, next_ok;
  assign s.ready = ready_q & ~full;
  assign active = (state == RUN) & motor;
  assign wrap = pre == PW'(T_DIV - 1);
  assign next_ok = ~empty & (head != '0);
  tape_fifo #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_fifo (
    .clk(clk), .reset_n(reset_n), .flush(state == IDLE), .push(s.valid & s.ready), .pop(pop),
    .wdata(s.data), .rdata(head), .full(full), .empty(empty), .level(fifo_level)
  );
  always_comb begin
    state_n = state;
    pre_n = pre;
    cnt_n = cnt;
    lvl_n = tape_in;
    und_n = underrun;
    pop = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: if (!empty) begin
        pop = 1'b1;
        lvl_n = next_ok ? tape_in : 1'b0;
        cnt_n = next_ok ? head : cnt;
        pre_n = next_ok ? '0 : pre;
        state_n = next_ok ? RUN : FETCH;
      end
      RUN: if (!motor) state_n = HOLD;
      else if (ce) begin
        pre_n = wrap ? '0 : pre + 1'b1;
        cnt_n = wrap ? cnt - 1'b1 : cnt;
        // pulse end: chain straight into the next entry so back-to-back pulses have no gap
        if (wrap && cnt == LEN_W'(1)) begin
          pop = ~empty;
          lvl_n = (empty | next_ok) ? ~tape_in : 1'b0;
          cnt_n = next_ok ? head : '0;
          und_n = underrun | empty;
          state_n = next_ok ? RUN : FETCH;
        end
      end
      HOLD: state_n = motor ? RUN : HOLD;
      default: state_n = IDLE;
    endcase
    if (!play) begin
      state_n = IDLE;
      pre_n = '0;
      cnt_n = '0;
      lvl_n = 1'b0;
      und_n = 1'b0;
      pop = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pre <= '0;
      cnt <= '0;
      tape_in <= 1'b0;
      underrun <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state <= state_n;
      pre <= pre_n;
      cnt <= cnt_n;
      tape_in <= lvl_n;
      underrun <= und_n;
      ready_q <= play;
    end
endmodule

// File: tb/tb_amstrad_tape_pulse_player.sv
// tb_amstrad_tape_pulse_player: scoreboard bench matching tape_in edges against expected pulse timing
module tb_amstrad_tape_pulse_player;
  typedef struct {
    logic lvl;
    int   ticks;
    logic und;
  } ev_t;
  logic clk = 0, reset_n = 0, ce = 0, play = 0, motor = 0;
  logic tape_in, active, underrun;
  logic [2:0] fifo_level;
  ev_t q[$];
  ev_t e;
  int checks = 0, errors = 0, ticks = 0, n;
  logic exp_lvl = 0, last = 0;
  bit mon_en = 0;
  amstrad_tape_pulse_player_if #(.LEN_W(16)) s();
  amstrad_tape_pulse_player #(.DEPTH(4), .LEN_W(16), .T_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .play(play), .motor(motor), .s(s),
    .tape_in(tape_in), .active(active), .underrun(underrun), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (3) @(negedge clk);
    ce = 1;
    @(negedge clk);
    ce = 0;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // ticks counts ce pulses the DUT will consume at the coming edge while running
  initial forever begin
    @(negedge clk);
    #1;
    if (!mon_en) begin
      last = tape_in;
      ticks = 0;
    end else begin
      if (tape_in !== last) begin
        if (q.size() == 0) check("spurious_edge", tape_in, last);
        else begin
          e = q.pop_front();
          check("edge_level", tape_in, e.lvl);
          check("edge_ticks", ticks, e.ticks);
          check("edge_underrun", underrun, e.und);
        end
        last = tape_in;
        ticks = 0;
      end
      if (ce && active) ticks++;
    end
  end
  task automatic push_pulse(input int len, input logic und, input bit track);
    bit ok = 0;
    @(negedge clk);
    s.valid = 1;
    s.data = 16'(len);
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (s.ready) ok = 1;
      else @(negedge clk);
    end
    if (!ok) check("push_timeout", 0, 1);
    @(negedge clk);
    s.valid = 0;
    if (ok && track && !(len == 0 && exp_lvl == 0)) begin
      exp_lvl = len == 0 ? 1'b0 : ~exp_lvl;
      q.push_back('{exp_lvl, len * 4, und});
    end
  endtask
  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim && q.size() > 0; i++) @(negedge clk);
    check("drain", q.size(), 0);
  endtask
  task automatic sync_ce();
    do @(posedge clk); while (!ce);
    @(negedge clk);
  endtask
  task automatic flush();
    @(negedge clk);
    mon_en = 0;
    play = 0;
    repeat (2) @(negedge clk);
    exp_lvl = 0;
    mon_en = 1;
    play = 1;
  endtask
  initial begin
    s.valid = 0;
    s.data = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tape_in", tape_in, 0);
    check("rst_active", active, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", s.ready, 0);
    check("rst_level", fifo_level, 0);
    @(negedge clk);
    reset_n = 1;
    mon_en = 1;
    play = 1;
    motor = 1;
    push_pulse(3, 1, 1);
    wait_drain(200);
    check("t1_underrun", underrun, 1);
    motor = 0;
    flush();
    check("t2_underrun_clear", underrun, 0);
    push_pulse(2, 0, 1);
    push_pulse(2, 0, 1);
    push_pulse(2, 1, 1);
    repeat (2) @(negedge clk);
    check("t2_prefill", fifo_level, 2);
    sync_ce();
    motor = 1;
    wait_drain(400);
    push_pulse(5, 1, 1);
    for (int i = 0; i < 200 && ticks < 8; i++) begin
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    motor = 0;
    repeat (400) @(negedge clk);
    #2;
    check("t3_active_hold", active, 0);
    check("t3_pending", q.size(), 1);
    sync_ce();
    motor = 1;
    wait_drain(200);
    push_pulse(1, 1, 1);
    wait_drain(100);
    push_pulse(0, 1, 1);
    push_pulse(4, 1, 1);
    wait_drain(200);
    motor = 0;
    flush();
    push_pulse(10, 0, 1);
    repeat (3) @(negedge clk);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s.valid = n < 6;
      s.data = 16'(n + 1);
      #1;
      if (s.valid && s.ready) begin
        n++;
        exp_lvl = ~exp_lvl;
        q.push_back('{exp_lvl, 4 * n, n == 4});
      end
    end
    @(negedge clk);
    s.valid = 0;
    #1;
    check("t5_accepted", n, 4);
    check("t5_level", fifo_level, 4);
    check("t5_ready_full", s.ready, 0);
    sync_ce();
    motor = 1;
    wait_drain(800);
    flush();
    push_pulse(1, 0, 1);
    push_pulse(50, 0, 0);
    push_pulse(7, 0, 0);
    wait_drain(200);
    repeat (2) @(negedge clk);
    #1;
    check("t6_ready_pre", s.ready, 1);
    check("t6_level_pre", fifo_level, 1);
    check("t6_tape_pre", tape_in, 1);
    @(negedge clk);
    mon_en = 0;
    play = 0;
    @(negedge clk);
    #1;
    check("t6_stop_ready", s.ready, 0);
    check("t6_stop_tape", tape_in, 0);
    check("t6_stop_underrun", underrun, 0);
    @(negedge clk);
    #1;
    check("t6_stop_level", fifo_level, 0);
    check("t6_stop_active", active, 0);
    @(negedge clk);
    play = 1;
    push_pulse(1, 0, 0);
    push_pulse(50, 0, 0);
    push_pulse(7, 0, 0);
    repeat (30) @(negedge clk);
    #1;
    check("t6_tape_mid", tape_in, 1);
    check("t6_level_mid", fifo_level, 1);
    #1 reset_n = 0;
    #1;
    check("t6_rst_tape", tape_in, 0);
    check("t6_rst_ready", s.ready, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_active", active, 0);
    @(negedge clk);
    reset_n = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
